// File: rtl/psum_collector_pkg.sv
// Shared constants and helpers for the systolic-array south-edge partial-sum collector.
package psum_collector_pkg;

  localparam int PSUM_BW    = 16;
  localparam int COL        = 8;
  localparam int FIFO_DEPTH = 64;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_collector_col_fifo.sv
// Single-column show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module col_fifo
  import psum_collector_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = FIFO_DEPTH,
  localparam int AW     = clog2(depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [psum_bw-1:0] in,
  output logic [psum_bw-1:0] out,
  output logic               empty,
  output logic               full,
  output logic [AW:0]        count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [psum_bw-1:0] r_mem [depth];
  logic [AW:0]        r_wp;
  logic [AW:0]        r_rp;
  logic               w_push;
  logic               w_pop;

  assign empty  = (r_wp == r_rp);
  assign full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign count  = r_wp - r_rp;
  assign w_pop  = rd && !empty;
  // A pop on the same edge frees the slot, so a full column may still accept.
  assign w_push = wr && (!full || w_pop);
  assign out    = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < depth; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp[AW-1:0]] <= in;
        r_wp                <= r_wp + PTR_ONE;
      end
      if (w_pop) r_rp <= r_rp + PTR_ONE;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Re-aligns skewed per-column partial sums into full rows for the SRAM writer.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int col     = COL,
  parameter int depth   = FIFO_DEPTH,
  localparam int CW     = clog2(depth) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_overflow,
  output logic [CW-1:0]          o_count
);

  logic [col-1:0] w_empty;
  logic [col-1:0] w_full;
  logic [CW-1:0]  w_count [col];
  logic           w_pop;
  logic           w_drop;
  logic           r_overflow;

  assign o_valid = &(~w_empty);
  assign o_full  = |w_full;
  assign w_pop   = rd && o_valid;

  for (genvar g = 0; g < col; g++) begin : g_col
    col_fifo #(
      .psum_bw(psum_bw),
      .depth  (depth)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .wr   (wr[g]),
      .rd   (w_pop),
      .in   (in[g*psum_bw +: psum_bw]),
      .out  (out[g*psum_bw +: psum_bw]),
      .empty(w_empty[g]),
      .full (w_full[g]),
      .count(w_count[g])
    );
  end

  always_comb begin
    o_count = '0;
    for (int i = 0; i < col; i++) begin
      if (w_count[i] > o_count) o_count = w_count[i];
    end
  end

  // Drop happens only on a full column that is not freed by a pop this edge.
  assign w_drop = (|(wr & w_full)) && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign o_overflow = r_overflow;

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Receiver for the south edge of the systolic array.
- Captures per-column partial sums whenever that column's valid bit is high, and buffers them in per-column FIFOs.
- Valid bits arrive skewed in time, one diagonal wavefront across the columns.
- Re-aligns the data into full output rows and hands them to the downstream SRAM writer through a valid/ready-style read handshake.

Parameters:
- psum_bw, 16, width of one partial sum
- col, 8, number of array columns
- depth, 64, entries per column FIFO; must be a power of 2, at least 2

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state)
- in  input  psum_bw*col  array south outputs; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]
- wr  input  col  per-column write strobe; the array's per-column valid
- rd  input  1  pop one aligned row
- out  output  psum_bw*col  head row, same column packing as in
- o_valid  output  1  every column FIFO is non-empty
- o_full  output  1  any column FIFO is full
- o_overflow  output  1  sticky: a write was dropped
- o_count  output  log2(depth)+1  occupancy of the fullest column

Behaviour:
- Reset (async assert, sync release):
  - all read/write pointers = 0, o_overflow = 0
  - o_valid = 0, o_full = 0, o_count = 0
  - out = 0, because the storage is cleared on reset
- Per-column FIFO c:
  - One write port, one read port, show-ahead.
  - Pointers are log2(depth)+1 bits wide.
  - empty = (wp == rp); full = MSBs differ and the lower bits are equal.
  - Pointers wrap naturally modulo 2*depth.
- Write, column c:
  - on posedge, if wr[c] and (!full_c or pop), store in[c] at wp_c and increment wp_c
  - if wr[c] and full_c and !pop: data dropped, wp_c unchanged, o_overflow set to 1 (stays 1 until reset)
- Pop:
  - pop = rd & o_valid
  - when pop, every rp_c increments on the same edge
  - rd while !o_valid is ignored: no pointer change, no error flag
- Outputs:
  - out = concatenation of the head entries of all columns, combinational from storage and rp
  - o_valid, o_full and o_count are combinational from the pointers
- Latency: a write on edge t can be at the head and contribute to o_valid from cycle t+1 onward; no same-cycle bypass from in to out.
- Simultaneous write and pop on a full column: allowed; occupancy stays at depth and no overflow is flagged.
- Simultaneous write and pop on a column holding exactly one entry: the popped entry leaves, the new entry becomes head, and the column is still non-empty.
- Skewed arrival: column c may lead or lag column c+1 by any number of cycles. A row is released only when the slowest column has its entry, so alignment is independent of skew.
- o_count = max over c of (wp_c - rp_c).
- Reset mid-operation: all buffered data is discarded immediately and asynchronously, and o_overflow clears.
- No state machine beyond the pointers. This is a buffering block; correctness is defined entirely by the pointer rules above.

Decomposition:
- Shared package/header holds:
  - the default constants PSUM_BW = 16, COL = 8, FIFO_DEPTH = 64
  - a clog2 helper for pointer width
- One natural sub-module, col_fifo (parameters psum_bw, depth; ports clk, reset, wr, rd, in, out, empty, full, count).
  - Instantiated col times via generate.
  - Its rd is driven by the shared pop.
  - The top level does the AND-reduction for o_valid, the OR-reduction for o_full, the max for o_count, and the overflow flag.

Test Plan:
- Reset mid-stream:
  - Stimulus: fill 5 rows, pull reset low for half a cycle.
  - Response: o_valid = 0, o_count = 0, o_overflow = 0 immediately.
  - Then: a new write of 0x0001 on all columns gives out = 0x0001 in every column one cycle later.
- Skewed diagonal:
  - Stimulus: wr[c] pulses at cycle 10+c with in[c] = 0x1000+c, for c = 0..7.
  - Response: o_valid rises only at cycle 18.
  - out columns = 0x1000..0x1007; rd pops them and o_valid falls to 0.
- Streaming order:
  - Stimulus: 20 rows written with skew 1 and value row*16+c, with rd held high.
  - Response: rows emerge in order, each column value matches, no row is repeated or lost.
- Full / overflow:
  - Stimulus: write depth = 64 rows with rd = 0.
  - Response: o_full = 1, o_count = 64.
  - A 65th write gives o_overflow = 1, and the 64 original rows still read back intact.
- Full plus simultaneous pop:
  - Stimulus: at full, assert wr = 0xFF together with rd.
  - Response: o_overflow stays 0 and o_count stays 64.
  - The new row is read back last.
- Empty read and wrap:
  - Stimulus: rd = 1 with no data.
  - Response: pointers unchanged.
  - Follow-up: 200 write/read pairs through depth 64, crossing the wrap point 3 times; data stays correct and o_count never exceeds 1.
